// File: rtl/seg7_scan_decoder.sv
// Readback decoder for a multiplexed common-anode 7-segment scan bus.
// Define SEG_SCAN_SYNC_EN to add a two-flop input synchronizer.
module seg7_scan_decoder #(
    parameter int NDIG          = 4,
    parameter int IDX_W         = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          seg_in,
    input  logic [NDIG-1:0]     dig_en,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     dps,
    output logic [NDIG-1:0]     digit_vld,
    output logic                upd_stb,
    output logic [IDX_W-1:0]    upd_idx,
    output logic                err_stb,
    output logic [7:0]          err_cnt
);

    logic [7:0]      seg_s;
    logic [NDIG-1:0] en_s;

`ifdef SEG_SCAN_SYNC_EN
    logic [7:0]      seg_m;
    logic [NDIG-1:0] en_m;

    // Idle bus on reset: all enables high keeps the filter unqualified
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_m <= '1;
            en_m  <= '1;
            seg_s <= '1;
            en_s  <= '1;
        end else begin
            seg_m <= seg_in;
            en_m  <= dig_en;
            seg_s <= seg_m;
            en_s  <= en_m;
        end
    end
`else
    assign seg_s = seg_in;
    assign en_s  = dig_en;
`endif

    logic [NDIG-1:0]  onehot;
    logic             qual;
    logic [IDX_W-1:0] samp_idx;

    always_comb begin
        onehot   = ~en_s;
        qual     = (onehot != '0) &&
                   ((onehot & (onehot - NDIG'(1))) == '0);
        samp_idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (onehot[i]) samp_idx = IDX_W'(i);
        end
    end

    logic [7:0]       prev_seg;
    logic [NDIG-1:0]  prev_en;
    logic [IDX_W-1:0] prev_idx;
    logic [7:0]       cnt;
    logic             acc;
    logic             fire;
    logic             same;
    logic [4:0]       dec;
    logic             blank;

    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        r = 5'h00;
        case (p)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        fire  = (cnt == 8'(STABLE_CYCLES)) && !acc;
        same  = ({seg_s, en_s} == {prev_seg, prev_en});
        dec   = decode(prev_seg[6:0]);
        blank = (prev_seg[6:0] == 7'h7F);
    end

    // Acceptance decodes the stored sample; the filter then absorbs this edge
    always_ff @(posedge clk) begin
        if (rst) begin
            digits    <= '0;
            dps       <= '0;
            digit_vld <= '0;
            upd_stb   <= 1'b0;
            upd_idx   <= '0;
            err_stb   <= 1'b0;
            err_cnt   <= '0;
            prev_seg  <= '0;
            prev_en   <= '0;
            prev_idx  <= '0;
            cnt       <= '0;
            acc       <= 1'b0;
        end else begin
            upd_stb <= 1'b0;
            err_stb <= 1'b0;
            if (fire) begin
                upd_idx <= prev_idx;
                if (dec[4]) begin
                    digits[{prev_idx, 2'b00} +: 4] <= dec[3:0];
                    dps[prev_idx]       <= ~prev_seg[7];
                    digit_vld[prev_idx] <= 1'b1;
                    upd_stb             <= 1'b1;
                end else if (blank) begin
                    dps[prev_idx]       <= ~prev_seg[7];
                    digit_vld[prev_idx] <= 1'b0;
                    upd_stb             <= 1'b1;
                end else begin
                    digit_vld[prev_idx] <= 1'b0;
                    err_stb             <= 1'b1;
                    if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                end
            end
            if (!qual) begin
                cnt <= '0;
                acc <= 1'b0;
            end else if (same) begin
                if (cnt != 8'(STABLE_CYCLES)) cnt <= cnt + 8'd1;
                acc <= acc | fire;
            end else begin
                cnt      <= 8'd1;
                acc      <= 1'b0;
                prev_seg <= seg_s;
                prev_en  <= en_s;
                prev_idx <= samp_idx;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: run-length reference model plus directed checks.
module tb_seg7_scan_decoder;

    localparam int NDIG = 4;
    localparam int IDX_W = 2;
    localparam int SC = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [7:0]        seg_in = 8'hFF;
    logic [NDIG-1:0]   dig_en = '1;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   dps;
    logic [NDIG-1:0]   digit_vld;
    logic              upd_stb;
    logic [IDX_W-1:0]  upd_idx;
    logic              err_stb;
    logic [7:0]        err_cnt;

    seg7_scan_decoder #(.NDIG(NDIG), .IDX_W(IDX_W), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .seg_in(seg_in), .dig_en(dig_en),
        .digits(digits), .dps(dps), .digit_vld(digit_vld),
        .upd_stb(upd_stb), .upd_idx(upd_idx), .err_stb(err_stb),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int stb_count = 0;
    int err_count = 0;

    logic [6:0] pat [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                            7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                            7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        bit              q;
        logic [7:0]      s;
        logic [NDIG-1:0] e;
    } samp_t;

    samp_t hist[$];

    logic [4*NDIG-1:0] m_digits = '0;
    logic [NDIG-1:0]   m_dps = '0;
    logic [NDIG-1:0]   m_vld = '0;
    logic              m_upd = 1'b0;
    logic [IDX_W-1:0]  m_idx = '0;
    logic              m_err = 1'b0;
    int                m_ecnt = 0;

    function automatic int run_len();
        int n = 0;
        samp_t last;
        if (hist.size() == 0) return 0;
        last = hist[hist.size()-1];
        if (!last.q) return 0;
        for (int k = hist.size() - 1; k >= 0; k--) begin
            if (hist[k].q && hist[k].s == last.s && hist[k].e == last.e)
                n++;
            else
                break;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        samp_t cur;
        samp_t last;
        int d;
        int v;
        m_upd = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            m_digits = '0; m_dps = '0; m_vld = '0;
            m_idx = '0; m_ecnt = 0;
            cur.q = 1'b0; cur.s = '0; cur.e = '0;
        end else begin
            if (run_len() == SC) begin
                last = hist[hist.size()-1];
                d = 0;
                for (int i = 0; i < NDIG; i++) if (!last.e[i]) d = i;
                v = -1;
                for (int i = 0; i < 16; i++) if (pat[i] == last.s[6:0]) v = i;
                m_idx = IDX_W'(d);
                if (v >= 0) begin
                    m_digits[d*4 +: 4] = 4'(v);
                    m_dps[d] = ~last.s[7];
                    m_vld[d] = 1'b1;
                    m_upd = 1'b1;
                end else if (last.s[6:0] == 7'h7F) begin
                    m_dps[d] = ~last.s[7];
                    m_vld[d] = 1'b0;
                    m_upd = 1'b1;
                end else begin
                    m_vld[d] = 1'b0;
                    m_err = 1'b1;
                    if (m_ecnt < 255) m_ecnt++;
                end
            end
            cur.q = ($countones(~dig_en) == 1);
            cur.s = seg_in;
            cur.e = dig_en;
        end
        hist.push_back(cur);
        if (hist.size() > 16) void'(hist.pop_front());
        #1;
        n_cmp++;
        if (digits !== m_digits || dps !== m_dps || digit_vld !== m_vld ||
            upd_stb !== m_upd || upd_idx !== m_idx || err_stb !== m_err ||
            err_cnt !== 8'(m_ecnt)) begin
            n_bad++;
            $display("FAIL outputs t=%0t got dig=%h dp=%b vld=%b upd=%b idx=%0d err=%b ecnt=%0d want dig=%h dp=%b vld=%b upd=%b idx=%0d err=%b ecnt=%0d",
                $time, digits, dps, digit_vld, upd_stb, upd_idx, err_stb,
                err_cnt, m_digits, m_dps, m_vld, m_upd, m_idx, m_err, m_ecnt);
        end
        if (upd_stb === 1'b1) stb_count++;
        if (err_stb === 1'b1) err_count++;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [NDIG-1:0] en_of(input int d);
        return ~(NDIG'(1) << d);
    endfunction

    task automatic drive(input logic [7:0] s, input logic [NDIG-1:0] e,
                         input int n);
        repeat (n) begin
            @(negedge clk);
            seg_in = s;
            dig_en = e;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; seg_in = 8'hFF; dig_en = '1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    logic [7:0] scan_pat [4] = '{8'hC0, 8'hF9, 8'h8E, 8'h7F};
    int s0;
    int e0;

    initial begin
        do_reset();
        chk("reset_digits", 32'(digits), 32'h0);
        chk("reset_vld", 32'(digit_vld), 32'h0);
        chk("reset_ecnt", 32'(err_cnt), 32'h0);

        drive(8'hA4, 4'b1110, 5);
        @(negedge clk);
        chk("t1_upd", 32'(upd_stb), 32'h1);
        chk("t1_idx", 32'(upd_idx), 32'h0);
        chk("t1_d0", 32'(digits[3:0]), 32'h2);
        chk("t1_dps", 32'(dps), 32'h0);
        chk("t1_vld", 32'(digit_vld), 32'b0001);
        s0 = stb_count;
        drive(8'hA4, 4'b1110, 6);
        @(negedge clk);
        chk("t1_no_refire", 32'(stb_count - s0), 32'h0);

        s0 = stb_count;
        for (int p = 0; p < 3; p++)
            for (int d = 0; d < 4; d++)
                drive(scan_pat[d], en_of(d), 6);
        @(negedge clk);
        chk("scan_strobes", 32'(stb_count - s0), 32'd12);
        chk("scan_digits", 32'(digits[11:0]), 32'hF10);
        chk("scan_vld", 32'(digit_vld), 32'b0111);
        chk("scan_dps", 32'(dps), 32'b1000);

        s0 = stb_count;
        drive(8'h80, en_of(2), 3);
        drive(8'h90, en_of(2), 5);
        @(negedge clk);
        chk("d2_strobes", 32'(stb_count - s0), 32'd1);
        chk("d2_value", 32'(digits[11:8]), 32'h9);

        e0 = err_count;
        drive(8'h55, en_of(1), 5);
        @(negedge clk);
        chk("err_strobes", 32'(err_count - e0), 32'd1);
        chk("err_cnt1", 32'(err_cnt), 32'd1);
        chk("err_vld1", 32'(digit_vld[1]), 32'h0);
        chk("err_d1_kept", 32'(digits[7:4]), 32'h1);
        for (int k = 0; k < 300; k++)
            drive((k % 2 == 0) ? 8'h56 : 8'h55, en_of(1), 5);
        @(negedge clk);
        chk("err_sat", 32'(err_cnt), 32'd255);

        s0 = stb_count;
        e0 = err_count;
        drive(8'hF9, 4'b1100, 10);
        drive(8'hF9, 4'b1111, 10);
        @(negedge clk);
        chk("unq_strobes", 32'(stb_count - s0 + err_count - e0), 32'd0);
        chk("unq_digits", 32'(digits), 32'h0910);
        drive(8'hF9, 4'b1011, 5);
        @(negedge clk);
        chk("unq_idx2", 32'(upd_idx), 32'h2);
        chk("unq_d2", 32'(digits[11:8]), 32'h1);

        s0 = stb_count;
        drive(8'hC0, 4'b1110, 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_no_early", 32'(stb_count - s0), 32'd0);
        @(negedge clk);
        chk("rst_upd", 32'(upd_stb), 32'h1);
        chk("rst_vld", 32'(digit_vld), 32'b0001);
        chk("rst_digits", 32'(digits), 32'h0);

        for (int k = 0; k < 400; k++) begin
            logic [7:0] s;
            logic [NDIG-1:0] e;
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 7) s = {1'($urandom), pat[$urandom_range(0, 15)]};
            else if (sel < 8) s = {1'($urandom), 7'h7F};
            else s = 8'($urandom);
            if ($urandom_range(0, 99) < 85) e = en_of($urandom_range(0, NDIG - 1));
            else e = NDIG'($urandom);
            if ($urandom_range(0, 99) < 3) begin
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
            drive(s, e, $urandom_range(1, 7));
        end
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
